// File: rtl/rib_lsu_master.sv
// rtl/rib_lsu_master.sv - RIB bus initiator: one LSU load/store command becomes one RIB transaction.
// Optional bus-wait abort is enabled by defining RIB_TIMEOUT_EN.
module rib_lsu_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_valid,
  output logic        o_lsu_ready,
  input  logic        i_lsu_we,
  input  logic [31:0] i_lsu_addr,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_unsigned,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_done,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_err,
  output logic [31:0] o_ribm_addr,
  output logic        o_ribm_wrcs,
  output logic [3:0]  o_ribm_mask,
  output logic [31:0] o_ribm_wdata,
  input  logic [31:0] i_ribm_rdata,
  output logic        o_ribm_req,
  input  logic        i_ribm_gnt,
  input  logic        i_ribm_rsp,
  output logic        o_ribm_rdy
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        tmo_hit;
  logic [31:0] load_result;

  function automatic logic [3:0] gen_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] gen_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    return {4{wdata[7:0]}};
      2'd1:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic bad_cmd(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] size,
                                          input logic [1:0] off, input logic uns);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (size)
      2'd0:    return {{24{~uns & lane[7]}}, lane[7:0]};
      2'd1:    return {{16{~uns & lane[15]}}, lane[15:0]};
      default: return rdata;
    endcase
  endfunction

  assign o_lsu_ready = (state == IDLE);
  // Stores complete with zero read data; only loads pass the lane through.
  assign load_result = o_ribm_wrcs ? 32'h0 : extract(i_ribm_rdata, size_q, o_ribm_addr[1:0], uns_q);

`ifdef RIB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = (state == REQ || state == RSP) &&
                   ((tmo_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk) begin
    if (i_rst || state == IDLE)
      tmo_cnt <= '0;
    else if (state == REQ || state == RSP)
      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_ribm_req   <= 1'b0;
      o_ribm_rdy   <= 1'b0;
      o_lsu_done   <= 1'b0;
      o_lsu_err    <= 1'b0;
      o_lsu_rdata  <= 32'h0;
      o_ribm_addr  <= 32'h0;
      o_ribm_wdata <= 32'h0;
      o_ribm_mask  <= 4'h0;
      o_ribm_wrcs  <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_lsu_valid) begin
            o_ribm_addr  <= i_lsu_addr;
            o_ribm_wrcs  <= i_lsu_we;
            o_ribm_mask  <= gen_mask(i_lsu_size, i_lsu_addr[1:0]);
            o_ribm_wdata <= gen_wdata(i_lsu_size, i_lsu_wdata);
            size_q       <= i_lsu_size;
            uns_q        <= i_lsu_unsigned;
            if (bad_cmd(i_lsu_size, i_lsu_addr[1:0])) begin
              state       <= DONE;
              o_lsu_done  <= 1'b1;
              o_lsu_err   <= 1'b1;
              o_lsu_rdata <= 32'h0;
            end else begin
              state      <= REQ;
              o_ribm_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (i_ribm_gnt) begin
            o_ribm_req <= 1'b0;
            // A slave may answer in the grant cycle; skip RSP in that case.
            if (i_ribm_rsp) begin
              state       <= DONE;
              o_lsu_done  <= 1'b1;
              o_lsu_rdata <= load_result;
            end else begin
              state      <= RSP;
              o_ribm_rdy <= 1'b1;
            end
          end else if (tmo_hit) begin
            o_ribm_req <= 1'b0;
            state      <= DONE;
            o_lsu_done <= 1'b1;
            o_lsu_err  <= 1'b1;
          end
        end
        RSP: begin
          if (i_ribm_rsp && o_ribm_rdy) begin
            o_ribm_rdy  <= 1'b0;
            state       <= DONE;
            o_lsu_done  <= 1'b1;
            o_lsu_rdata <= load_result;
          end else if (tmo_hit) begin
            o_ribm_rdy <= 1'b0;
            state      <= DONE;
            o_lsu_done <= 1'b1;
            o_lsu_err  <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          o_lsu_done  <= 1'b0;
          o_lsu_err   <= 1'b0;
          o_lsu_rdata <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
